// File: rtl/pim_page_mc.sv
// pim_page_mc: processing-in-memory page with NUM_EXEC pipelined ALU executors.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (NOP/WRITE/READ/ALU ops)
//   cmd_op, cmd_a/b/d        opcode, operand A, operand B, destination address
//   cmd_wdata                WRITE data
//   rd_data/rd_valid         READ result, one cycle after accept
//   exec_busy                per-executor in-flight flag
//   dma_en/we/addr/wdata     DMA access port (top priority)
//   dma_rdata/rvalid/err     DMA read result and busy-address refusal pulse
module pim_page_mc #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned NUM_EXEC     = 4,
    parameter int unsigned EXEC_LATENCY = 2,
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [AW-1:0]         cmd_a,
    input  logic [AW-1:0]         cmd_b,
    input  logic [AW-1:0]         cmd_d,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [NUM_EXEC-1:0]   exec_busy,
    input  logic                  dma_en,
    input  logic                  dma_we,
    input  logic [AW-1:0]         dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_rvalid,
    output logic                  dma_err
);
    localparam int unsigned PW = (NUM_EXEC > 1) ? $clog2(NUM_EXEC) : 1;
    localparam int unsigned CW = $clog2(EXEC_LATENCY) + 1;

    localparam logic [2:0] OpNop   = 3'd0;
    localparam logic [2:0] OpWrite = 3'd1;
    localparam logic [2:0] OpRead  = 3'd2;
    localparam logic [2:0] OpAdd   = 3'd3;
    localparam logic [2:0] OpSub   = 3'd4;
    localparam logic [2:0] OpAnd   = 3'd5;
    localparam logic [2:0] OpOr    = 3'd6;
    localparam logic [2:0] OpXor   = 3'd7;

    function automatic logic [DATA_WIDTH-1:0] alu(input logic [2:0] op,
                                                  input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] r;
        case (op)
            OpAdd:   r = a + b;
            OpSub:   r = a - b;
            OpAnd:   r = a & b;
            OpOr:    r = a | b;
            OpXor:   r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [NUM_EXEC-1:0]   busy_q, busy_d;
    logic [AW-1:0]         dest_q [NUM_EXEC];
    logic [AW-1:0]         dest_d [NUM_EXEC];
    logic [DATA_WIDTH-1:0] res_q  [NUM_EXEC];
    logic [DATA_WIDTH-1:0] res_d  [NUM_EXEC];
    logic [CW-1:0]         cnt_q  [NUM_EXEC];
    logic [CW-1:0]         cnt_d  [NUM_EXEC];
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, dma_rdata_q, dma_rdata_d;
    logic                  rd_valid_q, rd_valid_d, dma_rvalid_q, dma_rvalid_d;
    logic                  dma_err_q, dma_err_d;

    logic                  hz_a, hz_b, hz_d, hz_dma, hazard, is_alu, res_stall, accept;
    logic                  free_any, wb_any, dma_wr, grant;
    logic [PW-1:0]         free_idx, win, rr_sel;
    logic [NUM_EXEC-1:0]   wb_req;
    int unsigned           rr_idx;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        hz_a     = 1'b0;
        hz_b     = 1'b0;
        hz_d     = 1'b0;
        hz_dma   = 1'b0;
        free_any = 1'b0;
        free_idx = '0;
        wb_req   = '0;
        for (int unsigned n = 0; n < NUM_EXEC; n++) begin
            if (busy_q[n]) begin
                if (dest_q[n] == cmd_a)    hz_a   = 1'b1;
                if (dest_q[n] == cmd_b)    hz_b   = 1'b1;
                if (dest_q[n] == cmd_d)    hz_d   = 1'b1;
                if (dest_q[n] == dma_addr) hz_dma = 1'b1;
                // Result is ready once the latency countdown has reached zero.
                if (cnt_q[n] == '0)        wb_req[n] = 1'b1;
            end else if (!free_any) begin
                free_any = 1'b1;
                free_idx = PW'(n);
            end
        end

        is_alu    = (cmd_op >= OpAdd);
        hazard    = ((cmd_op != OpNop) && hz_a) || (is_alu && (hz_b || hz_d));
        wb_any    = |wb_req;
        // A command WRITE never competes with a writeback for the single write port.
        res_stall = (is_alu && !free_any) || ((cmd_op == OpWrite) && wb_any);
        cmd_ready = !rst && !dma_en && !hazard && !res_stall;
        accept    = cmd_valid && cmd_ready;
        dma_wr    = dma_en && dma_we;

        // Round-robin search starting at ptr_q; a DMA write blocks all writebacks.
        grant  = 1'b0;
        win    = '0;
        rr_idx = 0;
        rr_sel = '0;
        if (!dma_wr && !rst) begin
            for (int unsigned i = 0; i < NUM_EXEC; i++) begin
                rr_idx = 32'(ptr_q) + i;
                if (rr_idx >= NUM_EXEC) rr_idx = rr_idx - NUM_EXEC;
                rr_sel = PW'(rr_idx);
                if (!grant && wb_req[rr_sel]) begin
                    grant = 1'b1;
                    win   = rr_sel;
                end
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        ptr_d  = ptr_q;
        dest_d = dest_q;
        res_d  = res_q;
        cnt_d  = cnt_q;
        for (int unsigned n = 0; n < NUM_EXEC; n++) begin
            if (busy_q[n] && (cnt_q[n] != '0)) cnt_d[n] = cnt_q[n] - CW'(1);
        end
        if (grant) begin
            busy_d[win] = 1'b0;
            ptr_d       = (32'(win) == NUM_EXEC - 1) ? '0 : win + PW'(1);
        end
        if (accept && is_alu) begin
            busy_d[free_idx] = 1'b1;
            dest_d[free_idx] = cmd_d;
            cnt_d[free_idx]  = CW'(EXEC_LATENCY - 1);
            res_d[free_idx]  = alu(cmd_op, mem_q[cmd_a], mem_q[cmd_b]);
        end

        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (dma_wr) begin
                mem_we    = !hz_dma;
                mem_waddr = dma_addr;
                mem_wdata = dma_wdata;
            end else if (grant) begin
                mem_we    = 1'b1;
                mem_waddr = dest_q[win];
                mem_wdata = res_q[win];
            end else if (accept && (cmd_op == OpWrite)) begin
                mem_we    = 1'b1;
                mem_waddr = cmd_a;
                mem_wdata = cmd_wdata;
            end
        end

        rd_valid_d   = accept && (cmd_op == OpRead);
        rd_data_d    = rd_valid_d ? mem_q[cmd_a] : rd_data_q;
        dma_rvalid_d = dma_en && !dma_we;
        dma_rdata_d  = dma_rvalid_d ? (hz_dma ? '0 : mem_q[dma_addr]) : dma_rdata_q;
        dma_err_d    = dma_en && hz_dma;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            ptr_q        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            dma_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
            dma_err_q    <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            ptr_q        <= ptr_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            dma_rdata_q  <= dma_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_err_q    <= dma_err_d;
        end
        dest_q <= dest_d;
        res_q  <= res_d;
        cnt_q  <= cnt_d;
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign exec_busy  = busy_q;
    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;
    assign dma_err    = dma_err_q;
endmodule

// File: tb/tb_pim_page_mc.sv
// Testbench for pim_page_mc: directed stimulus with a scoreboard for READ and DMA read results.
module tb_pim_page_mc;
    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 1024;
    localparam int unsigned NE  = 4;
    localparam int unsigned LAT = 4;
    localparam int unsigned AW  = 10;

    localparam logic [2:0] OpWrite = 3'd1;
    localparam logic [2:0] OpRead  = 3'd2;
    localparam logic [2:0] OpAdd   = 3'd3;
    localparam logic [2:0] OpSub   = 3'd4;
    localparam logic [2:0] OpAnd   = 3'd5;
    localparam logic [2:0] OpOr    = 3'd6;
    localparam logic [2:0] OpXor   = 3'd7;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_a, cmd_b, cmd_d;
    logic [DW-1:0] cmd_wdata, rd_data;
    logic          rd_valid;
    logic [NE-1:0] exec_busy;
    logic          dma_en, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          dma_rvalid, dma_err;

    int n_checks = 0;
    int n_errors = 0;
    int waited;

    logic [DW-1:0] rd_q [$];
    logic [DW:0]   dma_q [$];

    pim_page_mc #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEP),
        .NUM_EXEC    (NE),
        .EXEC_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_d     (cmd_d),
        .cmd_wdata (cmd_wdata),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .exec_busy (exec_busy),
        .dma_en    (dma_en),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_rvalid(dma_rvalid),
        .dma_err   (dma_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected response whenever the DUT presents one.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rd_unexpected: actual 0x%0h required no response", rd_data);
                end else begin
                    check("rd_data", {1'b0, rd_data}, {1'b0, rd_q.pop_front()});
                end
            end
            if (dma_rvalid) begin
                if (dma_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL dma_unexpected: actual 0x%0h required no response", dma_rdata);
                end else begin
                    check("dma_err_rdata", {dma_err, dma_rdata}, dma_q.pop_front());
                end
            end
        end
    end

    // Offer a command and hold it until accepted; returns the number of stalled cycles.
    task automatic send(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] d, input logic [DW-1:0] w, output int stalls);
        stalls    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_d     = d;
        cmd_wdata = w;
        @(negedge clk);
        while (!cmd_ready && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: actual cmd_ready 0 required 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] w);
        int s;
        send(OpWrite, a, '0, '0, w, s);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int s;
        rd_q.push_back(exp);
        send(OpRead, a, '0, '0, '0, s);
    endtask

    task automatic do_alu(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] d);
        int s;
        send(op, a, b, d, '0, s);
    endtask

    task automatic dma_write(input logic [AW-1:0] a, input logic [DW-1:0] w);
        dma_en    = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = a;
        dma_wdata = w;
        @(posedge clk);
        #1;
        dma_en = 1'b0;
        dma_we = 1'b0;
    endtask

    task automatic dma_read(input logic [AW-1:0] a, input logic exp_err, input logic [DW-1:0] exp);
        dma_q.push_back({exp_err, exp});
        dma_en   = 1'b1;
        dma_we   = 1'b0;
        dma_addr = a;
        @(posedge clk);
        #1;
        dma_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_d = '0; cmd_wdata = '0;
        dma_en = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", {32'd0, cmd_ready}, '0);
        check("rd_valid_reset", {32'd0, rd_valid}, '0);
        check("rd_data_reset", {1'b0, rd_data}, '0);
        check("busy_reset", {29'd0, exec_busy}, '0);
        check("dma_out_reset", {dma_rvalid, dma_rdata}, '0);
        check("dma_err_reset", {32'd0, dma_err}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {32'd0, cmd_ready}, 33'd1);
        @(posedge clk);
        #1;

        // Basic ADD, busy window and write-then-read.
        do_write(3, 32'h5);
        do_read(3, 32'h5);
        do_write(4, 32'h7);
        do_alu(OpAdd, 3, 4, 10);
        for (int i = 0; i < int'(LAT); i++) begin
            @(negedge clk);
            check("busy_during_add", {29'd0, exec_busy}, 33'h1);
        end
        @(negedge clk);
        check("busy_after_add", {29'd0, exec_busy}, '0);
        @(posedge clk);
        #1;
        do_read(10, 32'hC);

        // Wrapping arithmetic and bitwise ops.
        do_write(20, 32'h0);
        do_write(21, 32'h1);
        do_alu(OpSub, 20, 21, 22);
        do_read(22, 32'hFFFF_FFFF);
        do_alu(OpAdd, 22, 21, 28);
        do_read(28, 32'h0);
        do_write(23, 32'hF0F0);
        do_write(24, 32'hFFFF);
        do_alu(OpXor, 23, 24, 25);
        do_alu(OpAnd, 23, 24, 26);
        do_alu(OpOr, 23, 24, 27);
        do_read(25, 32'h0F0F);
        do_read(26, 32'hF0F0);
        do_read(27, 32'hFFFF);

        // RAW: read of a locked destination stalls for the full latency.
        do_alu(OpAdd, 10, 3, 10);
        rd_q.push_back(32'h11);
        send(OpRead, 10, '0, '0, '0, waited);
        check("raw_stall_cycles", 33'(waited), 33'(LAT));

        // NUM_EXEC+1 independent ops: the extra one waits for the first writeback.
        do_write(40, 32'h1C);
        do_write(41, 32'h0A);
        do_alu(OpAdd, 40, 41, 50);
        do_alu(OpSub, 40, 41, 51);
        do_alu(OpAnd, 40, 41, 52);
        do_alu(OpOr, 40, 41, 53);
        send(OpXor, 40, 41, 54, '0, waited);
        check("full_stall_cycles", 33'(waited), 33'd1);
        do_read(50, 32'h26);
        do_read(51, 32'h12);
        do_read(52, 32'h08);
        do_read(53, 32'h1E);
        do_read(54, 32'h16);

        // Reset with two ops in flight discards them.
        do_write(70, 32'h1);
        do_write(71, 32'h2);
        do_write(72, 32'h55);
        do_write(73, 32'h66);
        do_alu(OpAdd, 70, 71, 72);
        do_alu(OpSub, 70, 71, 73);
        rst = 1'b1;
        @(negedge clk);
        check("busy_two_inflight", {29'd0, exec_busy}, 33'h3);
        check("ready_mid_reset", {32'd0, cmd_ready}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("busy_after_mid_reset", {29'd0, exec_busy}, '0);
        @(posedge clk);
        #1;
        do_read(72, 32'h55);
        do_read(73, 32'h66);

        // Round-robin: pointer at 1 after one writeback from exec0; three finishers held by DMA.
        do_alu(OpOr, 40, 41, 83);
        repeat (LAT + 2) @(posedge clk);
        #1;
        do_alu(OpAdd, 40, 41, 80);
        do_alu(OpSub, 40, 41, 81);
        do_alu(OpXor, 40, 41, 82);
        dma_en = 1'b1; dma_we = 1'b1; dma_addr = 100; dma_wdata = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rr_held_by_dma", {29'd0, exec_busy}, 33'h7);
        check("dma_free_write_err", {32'd0, dma_err}, '0);
        @(posedge clk);
        #1;
        dma_en = 1'b0; dma_we = 1'b0;
        @(negedge clk);
        check("rr_step0", {29'd0, exec_busy}, 33'h7);
        @(negedge clk);
        check("rr_step1", {29'd0, exec_busy}, 33'h5);
        @(negedge clk);
        check("rr_step2", {29'd0, exec_busy}, 33'h1);
        @(negedge clk);
        check("rr_step3", {29'd0, exec_busy}, '0);
        @(posedge clk);
        #1;
        do_read(83, 32'h1E);
        do_read(80, 32'h26);
        do_read(81, 32'h12);
        do_read(82, 32'h16);

        // DMA against a busy destination: read returns 0 with err, write is dropped.
        do_write(60, 32'hAAAA);
        do_write(61, 32'h1);
        do_write(62, 32'h5555);
        do_alu(OpAdd, 60, 61, 62);
        dma_read(62, 1'b1, 32'h0);
        dma_write(62, 32'h1234);
        @(negedge clk);
        check("dma_busy_write_err", {dma_rvalid, 31'd0, dma_err}, 33'h1);
        @(negedge clk);
        check("dma_err_pulse_end", {32'd0, dma_err}, '0);
        @(posedge clk);
        #1;
        do_read(62, 32'hAAAB);

        // DMA read of a free address with a concurrent command that must stall.
        dma_q.push_back({1'b0, 32'hDEAD_BEEF});
        dma_en = 1'b1; dma_we = 1'b0; dma_addr = 100;
        cmd_valid = 1'b1; cmd_op = OpWrite; cmd_a = 90; cmd_wdata = 32'h77;
        @(negedge clk);
        check("ready_during_dma", {32'd0, cmd_ready}, '0);
        @(posedge clk);
        #1;
        dma_en = 1'b0;
        @(negedge clk);
        check("dma_rvalid_latency", {32'd0, dma_rvalid}, 33'd1);
        check("ready_after_dma", {32'd0, cmd_ready}, 33'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        do_read(90, 32'h77);
        do_read(100, 32'hDEAD_BEEF);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rd_queue_drained", 33'(rd_q.size()), '0);
        check("dma_queue_drained", 33'(dma_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
